// File: rtl/feature_loader_pkg.sv
// Shared widths, beat stride, FSM encodings and burst-length helper for the feature loader.
package feature_loader_pkg;

    localparam int FEATURE_WIDTH  = 16;
    localparam int MEM_DATA_WIDTH = 32 * FEATURE_WIDTH;
    localparam int ADDR_WIDTH     = 32;
    localparam int BURST_LEN      = 16;
    localparam int BEAT_BYTES     = MEM_DATA_WIDTH / 8;
    localparam int LEN_WIDTH      = 8;
    localparam int DIM_WIDTH      = 10;
    localparam int PIXEL_WIDTH    = 20;
    localparam int BEAT_CNT_WIDTH = 18;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_RDY  = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT_DATA = 3'd3,
        ST_DONE      = 3'd4
    } state_e;

    typedef enum logic {
        PATCH_1 = 1'b0,
        PATCH_2 = 1'b1
    } patch_e;

    function automatic logic [LEN_WIDTH-1:0] clamp_burst_len(
        input logic [BEAT_CNT_WIDTH-1:0] remaining
    );
        return (remaining >= BEAT_CNT_WIDTH'(BURST_LEN)) ? LEN_WIDTH'(BURST_LEN)
                                                          : remaining[LEN_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/feature_loader_patch_ctr.sv
// Per-patch read cursor: next burst address, beats still to request, and the
// length of the next burst clamped to BURST_LEN.
module feature_loader_patch_ctr
    import feature_loader_pkg::*;
(
    input  logic                      system_clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic [ADDR_WIDTH-1:0]     load_addr,
    input  logic [BEAT_CNT_WIDTH-1:0] load_beats,
    input  logic                      advance,
    output logic [ADDR_WIDTH-1:0]     addr,
    output logic [LEN_WIDTH-1:0]      burst_len,
    output logic                      has_beats
);

    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [BEAT_CNT_WIDTH-1:0] remaining_q, remaining_d;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        addr_d      = addr_q;
        remaining_d = remaining_q;
        if (load) begin
            addr_d      = load_addr;
            remaining_d = load_beats;
        end else if (advance) begin
            addr_d      = addr_q + ADDR_WIDTH'(burst_len) * ADDR_WIDTH'(BEAT_BYTES);
            remaining_d = remaining_q - BEAT_CNT_WIDTH'(burst_len);
        end
    end

    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge system_clk) begin
        if (rst) begin
            addr_q      <= '0;
            remaining_q <= '0;
        end else begin
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
        end
    end

    assign addr      = addr_q;
    assign burst_len = clamp_burst_len(remaining_q);
    assign has_beats = (remaining_q != '0);

endmodule

// File: rtl/feature_loader.sv
// Walks a feature map in memory with burst reads and forwards returned beats to
// the patch-1/patch-2 buffers. Define FEATURE_LOADER_PERF_EN to add stall_cycles.
module feature_loader
    import feature_loader_pkg::*;
(
    input  logic                      system_clk,
    input  logic                      rst,
    input  logic                      load_feature_begin,
    input  logic [ADDR_WIDTH-1:0]     feature_base_addr,
    input  logic [ADDR_WIDTH-1:0]     patch2_offset,
    input  logic [DIM_WIDTH-1:0]      row_size,
    input  logic [DIM_WIDTH-1:0]      col_size,
    input  logic                      feature_double_patch,
    output logic                      mem_rd_req,
    output logic [ADDR_WIDTH-1:0]     mem_rd_addr,
    output logic [LEN_WIDTH-1:0]      mem_rd_len,
    input  logic                      mem_rd_ack,
    input  logic [MEM_DATA_WIDTH-1:0] mem_rd_data,
    input  logic                      mem_rd_data_valid,
    output logic [MEM_DATA_WIDTH-1:0] feature_data,
    output logic                      feature_buffer_1_valid,
    output logic                      feature_buffer_2_valid,
    input  logic                      feature_buffer_1_ready,
    input  logic                      feature_buffer_2_ready,
    output logic                      load_feature_busy,
    output logic                      load_feature_finish
`ifdef FEATURE_LOADER_PERF_EN
    ,
    output logic [31:0]               stall_cycles
`endif
);

    state_e state_q, state_d;

    patch_e                    cur_patch_q, cur_patch_d;
    patch_e                    tgt_patch_q, tgt_patch_d;
    logic                      double_q, double_d;
    logic [LEN_WIDTH-1:0]      burst_len_q, burst_len_d;
    logic [LEN_WIDTH-1:0]      beat_cnt_q, beat_cnt_d;
    logic [MEM_DATA_WIDTH-1:0] feature_data_q, feature_data_d;
    logic                      buf1_valid_q, buf1_valid_d;
    logic                      buf2_valid_q, buf2_valid_d;
    logic                      finish_q, finish_d;

    logic [PIXEL_WIDTH-1:0]    pixels;
    logic [PIXEL_WIDTH-1:0]    pixels_rounded;
    logic [BEAT_CNT_WIDTH-1:0] beats_per_patch;

    logic                      start, ack_fire, accept, last_beat, more_beats, cur_ready;
    patch_e                    next_patch;
    logic [ADDR_WIDTH-1:0]     p1_addr, p2_addr, cur_addr;
    logic [LEN_WIDTH-1:0]      p1_len, p2_len, cur_len;
    logic                      p1_has, p2_has;

    // Max 1023*1023+3 still fits in 20 bits, so the round-up cannot overflow.
    assign pixels          = PIXEL_WIDTH'(row_size) * PIXEL_WIDTH'(col_size);
    assign pixels_rounded  = pixels + PIXEL_WIDTH'(3);
    assign beats_per_patch = pixels_rounded[PIXEL_WIDTH-1:2];

    always_comb begin
        start     = (state_q == ST_IDLE) && load_feature_begin;
        ack_fire  = (state_q == ST_ISSUE) && mem_rd_ack;
        accept    = (state_q == ST_WAIT_DATA) && mem_rd_data_valid;
        last_beat = accept && (beat_cnt_q == burst_len_q - LEN_WIDTH'(1));
        cur_addr  = (cur_patch_q == PATCH_1) ? p1_addr : p2_addr;
        cur_len   = (cur_patch_q == PATCH_1) ? p1_len : p2_len;
        cur_ready = (cur_patch_q == PATCH_1) ? feature_buffer_1_ready : feature_buffer_2_ready;
        more_beats = p1_has || (double_q && p2_has);
        // Alternate per burst, falling back to whichever patch still has beats.
        if (cur_patch_q == PATCH_1) begin
            next_patch = (double_q && p2_has) ? PATCH_2 : PATCH_1;
        end else begin
            next_patch = p1_has ? PATCH_1 : PATCH_2;
        end
    end

    feature_loader_patch_ctr u_patch1_ctr (
        .system_clk (system_clk),
        .rst        (rst),
        .load       (start),
        .load_addr  (feature_base_addr),
        .load_beats (beats_per_patch),
        .advance    (ack_fire && (cur_patch_q == PATCH_1)),
        .addr       (p1_addr),
        .burst_len  (p1_len),
        .has_beats  (p1_has)
    );

    feature_loader_patch_ctr u_patch2_ctr (
        .system_clk (system_clk),
        .rst        (rst),
        .load       (start),
        .load_addr  (feature_base_addr + patch2_offset),
        .load_beats (feature_double_patch ? beats_per_patch : '0),
        .advance    (ack_fire && (cur_patch_q == PATCH_2)),
        .addr       (p2_addr),
        .burst_len  (p2_len),
        .has_beats  (p2_has)
    );

    always_ff @(posedge system_clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (load_feature_begin) begin
                    state_d = (beats_per_patch == '0) ? ST_DONE : ST_WAIT_RDY;
                end
            end
            ST_WAIT_RDY:  if (cur_ready) state_d = ST_ISSUE;
            ST_ISSUE:     if (mem_rd_ack) state_d = ST_WAIT_DATA;
            ST_WAIT_DATA: if (last_beat) state_d = more_beats ? ST_WAIT_RDY : ST_DONE;
            ST_DONE:      state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_rd_req        = 1'b0;
        mem_rd_addr       = '0;
        mem_rd_len        = '0;
        load_feature_busy = (state_q != ST_IDLE);
        if (state_q == ST_ISSUE) begin
            mem_rd_req  = 1'b1;
            mem_rd_addr = cur_addr;
            mem_rd_len  = cur_len;
        end
    end

    always_comb begin
        cur_patch_d    = cur_patch_q;
        tgt_patch_d    = tgt_patch_q;
        double_d       = double_q;
        burst_len_d    = burst_len_q;
        beat_cnt_d     = beat_cnt_q;
        feature_data_d = feature_data_q;
        if (start) begin
            cur_patch_d = PATCH_1;
            double_d    = feature_double_patch;
        end
        if (ack_fire) begin
            tgt_patch_d = cur_patch_q;
            burst_len_d = cur_len;
            beat_cnt_d  = '0;
        end
        if (accept) begin
            beat_cnt_d     = beat_cnt_q + LEN_WIDTH'(1);
            feature_data_d = mem_rd_data;
        end
        if (last_beat && more_beats) begin
            cur_patch_d = next_patch;
        end
        buf1_valid_d = accept && (tgt_patch_q == PATCH_1);
        buf2_valid_d = accept && (tgt_patch_q == PATCH_2);
        finish_d     = (state_q == ST_DONE);
    end

    always_ff @(posedge system_clk) begin
        if (rst) begin
            cur_patch_q    <= PATCH_1;
            tgt_patch_q    <= PATCH_1;
            double_q       <= 1'b0;
            burst_len_q    <= '0;
            beat_cnt_q     <= '0;
            feature_data_q <= '0;
            buf1_valid_q   <= 1'b0;
            buf2_valid_q   <= 1'b0;
            finish_q       <= 1'b0;
        end else begin
            cur_patch_q    <= cur_patch_d;
            tgt_patch_q    <= tgt_patch_d;
            double_q       <= double_d;
            burst_len_q    <= burst_len_d;
            beat_cnt_q     <= beat_cnt_d;
            feature_data_q <= feature_data_d;
            buf1_valid_q   <= buf1_valid_d;
            buf2_valid_q   <= buf2_valid_d;
            finish_q       <= finish_d;
        end
    end

    assign feature_data           = feature_data_q;
    assign feature_buffer_1_valid = buf1_valid_q;
    assign feature_buffer_2_valid = buf2_valid_q;
    assign load_feature_finish    = finish_q;

`ifdef FEATURE_LOADER_PERF_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (start) begin
            stall_d = '0;
        end else if (((state_q == ST_WAIT_RDY) || ((state_q == ST_ISSUE) && !mem_rd_ack))
                     && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge system_clk) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule
